// File: rtl/alu_operand_stage_pkg.sv
// -----------------------------------------------------------------------------
// nf5_exe_pkg
// Shared definitions for the execute-stage operand select.
//   - operand source select encodings for s1 (sel1) and s2 (sel2)
//   - default operand/immediate/PC/lane/tag widths
//   - operand_widths_ok(): elaboration-time check of the width relationships
//     the operand build relies on
// -----------------------------------------------------------------------------
package nf5_exe_pkg;

    localparam int SIMD_W_DEF = 128;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int LANE_W_DEF = 32;
    localparam int TAG_W_DEF  = 5;

    // s1 source; 2'b11 is also constant zero
    localparam logic [1:0] SEL1_RS1  = 2'b00;
    localparam logic [1:0] SEL1_PC   = 2'b01;
    localparam logic [1:0] SEL1_ZERO = 2'b10;

    // s2 source
    localparam logic [1:0] SEL2_RS2   = 2'b00;
    localparam logic [1:0] SEL2_ZEXT  = 2'b01;
    localparam logic [1:0] SEL2_SEXT  = 2'b10;
    localparam logic [1:0] SEL2_BCAST = 2'b11;

    // Broadcast needs whole lanes taken from the immediate; PC and immediate
    // must fit inside one operand.
    function automatic bit operand_widths_ok(input int simd_w, input int data_w,
                                             input int addr_w, input int lane_w);
        return (lane_w > 0) && ((simd_w % lane_w) == 0) &&
               (addr_w <= simd_w) && (data_w >= lane_w) && (data_w <= simd_w);
    endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// -----------------------------------------------------------------------------
// alu_operand_stage_if
// Handshake and operand bus of the execute-stage operand select.
//   upstream  : flush, in_valid/in_ready, sel1, sel2, fwd_rs1, fwd_rs2,
//               now_pc, imm, in_tag
//   downstream: out_valid/out_ready, s1, s2, out_tag
// modport slave  : the operand stage itself
// modport master : the surrounding pipeline (ID/EX driver and ALU sink)
// -----------------------------------------------------------------------------
interface alu_operand_stage_if #(
    parameter int SIMD_W = 128,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        sel1;
    logic [1:0]        sel2;
    logic [SIMD_W-1:0] fwd_rs1;
    logic [SIMD_W-1:0] fwd_rs2;
    logic [ADDR_W-1:0] now_pc;
    logic [DATA_W-1:0] imm;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [SIMD_W-1:0] s1;
    logic [SIMD_W-1:0] s2;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  flush, in_valid, sel1, sel2, fwd_rs1, fwd_rs2, now_pc, imm, in_tag,
        input  out_ready,
        output in_ready, out_valid, s1, s2, out_tag
    );

    modport master (
        output flush, in_valid, sel1, sel2, fwd_rs1, fwd_rs2, now_pc, imm, in_tag,
        output out_ready,
        input  in_ready, out_valid, s1, s2, out_tag
    );
endinterface

// File: rtl/alu_operand_stage_skid.sv
// -----------------------------------------------------------------------------
// skid_buffer2
// Generic 2-entry valid/ready register slice (main + skid entry), strict FIFO.
// o_ready comes straight from a flop, so there is no combinational path from
// i_ready back to the producer.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_flush           : synchronous flush, empties both entries, wins over all
//   i_valid/o_ready   : input handshake, i_data captured on i_valid & o_ready
//   o_valid/i_ready   : output handshake, o_data transferred on o_valid & i_ready
// o_data holds its last value while o_valid is low.
// -----------------------------------------------------------------------------
module skid_buffer2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_main_valid;
    logic         r_skid_valid;
    logic [W-1:0] r_main_data;
    logic [W-1:0] r_skid_data;
    logic         w_accept;
    logic         w_drain;

    // The skid entry only fills while main is full, so "skid empty" is
    // exactly "room for one more".
    assign w_accept = i_valid & ~r_skid_valid;
    assign w_drain  = r_main_valid & i_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // Full: only a drain can happen; main stays valid with skid data.
            if (w_drain) r_skid_valid <= 1'b0;
        end else if (r_main_valid) begin
            if (w_accept && !w_drain)      r_skid_valid <= 1'b1;
            else if (!w_accept && w_drain) r_main_valid <= 1'b0;
        end else if (w_accept) begin
            r_main_valid <= 1'b1;
        end
    end

    // NOTE: the data entries are reset because the outputs must read zero out
    // of reset; they are deliberately not cleared on drain or flush so the
    // outputs hold their last value while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_data <= '0;
            r_skid_data <= '0;
        end else if (!i_flush) begin
            if (r_skid_valid) begin
                if (w_drain) r_main_data <= r_skid_data;
            end else if (w_accept) begin
                // Main free or emptying this edge: replace it; else park in skid.
                if (!r_main_valid || w_drain) r_main_data <= i_data;
                else                          r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = ~r_skid_valid;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

endmodule

// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
// Execute-stage operand select: builds SIMD operands s1/s2 from forwarded
// rs1/rs2, PC, immediate (zero-/sign-extended or lane-broadcast) or zero, and
// registers them with the tag in a 2-entry skid buffer (1-cycle latency,
// 1 transfer/cycle, registered in_ready).
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : alu_operand_stage_if.slave (flush, upstream handshake and
//                operand sources, downstream handshake s1/s2/out_tag)
// -----------------------------------------------------------------------------
module alu_operand_stage
    import nf5_exe_pkg::*;
#(
    parameter int SIMD_W = SIMD_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    alu_operand_stage_if.slave bus
);
    localparam int ENTRY_W = 2 * SIMD_W + TAG_W;

    if (!operand_widths_ok(SIMD_W, DATA_W, ADDR_W, LANE_W)) begin : g_bad_widths
        $error("alu_operand_stage: inconsistent SIMD_W/DATA_W/ADDR_W/LANE_W");
    end

    logic [SIMD_W-1:0]  w_s1;
    logic [SIMD_W-1:0]  w_s2;
    logic [ENTRY_W-1:0] w_in_data;
    logic [ENTRY_W-1:0] w_out_data;

    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_s1 = '0;
        w_s2 = '0;
        case (bus.sel1)
            SEL1_RS1: w_s1 = bus.fwd_rs1;
            SEL1_PC:  w_s1 = SIMD_W'(bus.now_pc);
            default:  w_s1 = '0;   // SEL1_ZERO and 2'b11
        endcase
        case (bus.sel2)
            SEL2_RS2:   w_s2 = bus.fwd_rs2;
            SEL2_ZEXT:  w_s2 = SIMD_W'(bus.imm);
            // Size cast of a signed operand sign-extends from bit DATA_W-1.
            SEL2_SEXT:  w_s2 = SIMD_W'($signed(bus.imm));
            SEL2_BCAST: w_s2 = {(SIMD_W / LANE_W){bus.imm[LANE_W-1:0]}};
            default:    w_s2 = '0;
        endcase
    end

    assign w_in_data = {w_s1, w_s2, bus.in_tag};

    skid_buffer2 #(.W(ENTRY_W)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.flush),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_in_data),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_data)
    );

    assign {bus.s1, bus.s2, bus.out_tag} = w_out_data;

endmodule
